// File: rtl/nn_f2_sched.sv
// nn_f2_sched: time-shares one layer-1 PE and one layer-2 PE across the four
// filter jobs of the f2 network.
//
// Job order (layer-1 filter / layer-2 filter -> destination quadrant):
//   j0: f1 / f1 -> out1[127:0]
//   j1: (map reused) / f2 -> out2[127:0]
//   j2: f3 / f3 -> out1[255:128]
//   j3: (map reused) / f4 -> out2[255:128]
//
// Handshake: start is a plain request qualified only by busy. A start seen
// while busy=0 (state IDLE, including the done cycle) is accepted on that
// edge. A start seen while busy=1 is dropped and never queued.
//
// PE operands (l1_img/l1_filt, l2_map/l2_filt) are registers. They change
// only on the phase transitions and hold their values in every other cycle.
module nn_f2_sched #(
  parameter int L1_LAT = 2,
  parameter int L2_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [287:0] in,
  input  logic [17:0]  filter1,
  input  logic [17:0]  filter2,
  input  logic [17:0]  filter3,
  input  logic [17:0]  filter4,
  output logic [287:0] l1_img,
  output logic [17:0]  l1_filt,
  input  logic [199:0] l1_result,
  output logic [199:0] l2_map,
  output logic [17:0]  l2_filt,
  input  logic [127:0] l2_result,
  output logic         l1_en,
  output logic         l2_en,
  output logic         busy,
  output logic         done,
  output logic [255:0] out1,
  output logic [255:0] out2,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_L1   = 2'd1,
    ST_L2   = 2'd2
  } state_t;

  localparam logic [7:0] L1_LAST = 8'(L1_LAT - 1);
  localparam logic [7:0] L2_LAST = 8'(L2_LAT - 1);

  state_t         state_q, state_d;
  logic [1:0]     j_q, j_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           done_q, done_d;
  logic [17:0]    f1_q, f1_d;
  logic [17:0]    f2_q, f2_d;
  logic [17:0]    f3_q, f3_d;
  logic [17:0]    f4_q, f4_d;
  logic [287:0]   l1_img_q, l1_img_d;
  logic [17:0]    l1_filt_q, l1_filt_d;
  logic [199:0]   map_q, map_d;
  logic [17:0]    l2_filt_q, l2_filt_d;
  logic [255:0]   out1_q, out1_d;
  logic [255:0]   out2_q, out2_d;

  // State and datapath registers; rst clears everything including results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      j_q       <= 2'd0;
      cnt_q     <= 8'd0;
      done_q    <= 1'b0;
      f1_q      <= '0;
      f2_q      <= '0;
      f3_q      <= '0;
      f4_q      <= '0;
      l1_img_q  <= '0;
      l1_filt_q <= '0;
      map_q     <= '0;
      l2_filt_q <= '0;
      out1_q    <= '0;
      out2_q    <= '0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      f1_q      <= f1_d;
      f2_q      <= f2_d;
      f3_q      <= f3_d;
      f4_q      <= f4_d;
      l1_img_q  <= l1_img_d;
      l1_filt_q <= l1_filt_d;
      map_q     <= map_d;
      l2_filt_q <= l2_filt_d;
      out1_q    <= out1_d;
      out2_q    <= out2_d;
    end
  end

  // Next-state logic: job sequencing, latency counting, captures and writes.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    f1_d      = f1_q;
    f2_d      = f2_q;
    f3_d      = f3_q;
    f4_d      = f4_q;
    l1_img_d  = l1_img_q;
    l1_filt_d = l1_filt_q;
    map_d     = map_q;
    l2_filt_d = l2_filt_q;
    out1_d    = out1_q;
    out2_d    = out2_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // The latched image doubles as the layer-1 image operand.
          l1_img_d  = in;
          l1_filt_d = filter1;
          f1_d      = filter1;
          f2_d      = filter2;
          f3_d      = filter3;
          f4_d      = filter4;
          j_d       = 2'd0;
          cnt_d     = 8'd0;
          state_d   = ST_L1;
        end
      end

      ST_L1: begin
        if (cnt_q == L1_LAST) begin
          map_d     = l1_result;
          cnt_d     = 8'd0;
          l2_filt_d = (j_q == 2'd2) ? f3_q : f1_q;
          state_d   = ST_L2;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_L2: begin
        if (cnt_q == L2_LAST) begin
          cnt_d = 8'd0;
          case (j_q)
            2'd0: begin
              out1_d[127:0] = l2_result;
              j_d           = 2'd1;
              l2_filt_d     = f2_q;
            end
            2'd1: begin
              out2_d[127:0] = l2_result;
              j_d           = 2'd2;
              l1_filt_d     = f3_q;
              state_d       = ST_L1;
            end
            2'd2: begin
              out1_d[255:128] = l2_result;
              j_d             = 2'd3;
              l2_filt_d       = f4_q;
            end
            default: begin
              out2_d[255:128] = l2_result;
              j_d             = 2'd0;
              done_d          = 1'b1;
              state_d         = ST_IDLE;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign l1_img    = l1_img_q;
  assign l1_filt   = l1_filt_q;
  assign l2_map    = map_q;
  assign l2_filt   = l2_filt_q;
  assign l1_en     = (state_q == ST_L1);
  assign l2_en     = (state_q == ST_L2);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nn_f2_sched.sv
// Testbench for nn_f2_sched: dut_a uses default latencies (2/2), dut_b uses
// L1_LAT=1, L2_LAT=5. Both share stimulus; each has its own PE models.
module tb_nn_f2_sched;

  logic         clk;
  logic         rst;
  logic         start;
  logic [287:0] in_img;
  logic [17:0]  f1, f2, f3, f4;

  logic [287:0] a_l1_img, b_l1_img;
  logic [17:0]  a_l1_filt, b_l1_filt;
  logic [199:0] a_l1_result, b_l1_result;
  logic [199:0] a_l2_map, b_l2_map;
  logic [17:0]  a_l2_filt, b_l2_filt;
  logic [127:0] a_l2_result, b_l2_result;
  logic         a_l1_en, a_l2_en, a_busy, a_done;
  logic         b_l1_en, b_l2_en, b_busy, b_done;
  logic [255:0] a_out1, a_out2, b_out1, b_out2;
  logic [1:0]   a_dbg_state, b_dbg_state;

  int n_checks;
  int n_errors;

  // Monitor records (cycle index relative to acceptance edge, -1 = never).
  int a_done_at, b_done_at, a_done_cnt, b_done_cnt;
  int a_l1_cnt, a_l2_cnt, b_l1_cnt, b_l2_cnt;
  int a_q_at[4];
  int b_q_at[4];

  localparam logic [287:0] IMG_A = {9{32'hA5C3_1E69}};

  // PE models: operands are stable through each evaluation window.
  assign a_l1_result = {182'b0, a_l1_filt};
  assign a_l2_result = {110'b0, a_l2_filt};
  assign b_l1_result = {182'b0, b_l1_filt};
  assign b_l2_result = {110'b0, b_l2_filt};

  nn_f2_sched dut_a (
    .clk(clk), .rst(rst), .start(start), .in(in_img),
    .filter1(f1), .filter2(f2), .filter3(f3), .filter4(f4),
    .l1_img(a_l1_img), .l1_filt(a_l1_filt), .l1_result(a_l1_result),
    .l2_map(a_l2_map), .l2_filt(a_l2_filt), .l2_result(a_l2_result),
    .l1_en(a_l1_en), .l2_en(a_l2_en), .busy(a_busy), .done(a_done),
    .out1(a_out1), .out2(a_out2), .dbg_state(a_dbg_state)
  );

  nn_f2_sched #(.L1_LAT(1), .L2_LAT(5)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in(in_img),
    .filter1(f1), .filter2(f2), .filter3(f3), .filter4(f4),
    .l1_img(b_l1_img), .l1_filt(b_l1_filt), .l1_result(b_l1_result),
    .l2_map(b_l2_map), .l2_filt(b_l2_filt), .l2_result(b_l2_result),
    .l1_en(b_l1_en), .l2_en(b_l2_en), .busy(b_busy), .done(b_done),
    .out1(b_out1), .out2(b_out2), .dbg_state(b_dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_filters(input logic [17:0] a, input logic [17:0] b,
                             input logic [17:0] c, input logic [17:0] d);
    f1 = a; f2 = b; f3 = c; f4 = d;
  endtask

  // Pulse start for one edge; returns after the acceptance edge.
  task automatic accept();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Observe both DUTs for cycles 0..budget after acceptance.
  task automatic run_monitor(input int budget);
    a_done_at = -1; b_done_at = -1; a_done_cnt = 0; b_done_cnt = 0;
    a_l1_cnt = 0; a_l2_cnt = 0; b_l1_cnt = 0; b_l2_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      a_q_at[k] = -1;
      b_q_at[k] = -1;
    end
    for (int i = 0; i <= budget; i++) begin
      if (i > 0) tick();
      if (a_l1_en) a_l1_cnt++;
      if (a_l2_en) a_l2_cnt++;
      if (b_l1_en) b_l1_cnt++;
      if (b_l2_en) b_l2_cnt++;
      if (a_done) begin a_done_cnt++; if (a_done_at < 0) a_done_at = i; end
      if (b_done) begin b_done_cnt++; if (b_done_at < 0) b_done_at = i; end
      if (a_q_at[0] < 0 && a_out1[127:0] != 0)   a_q_at[0] = i;
      if (a_q_at[1] < 0 && a_out2[127:0] != 0)   a_q_at[1] = i;
      if (a_q_at[2] < 0 && a_out1[255:128] != 0) a_q_at[2] = i;
      if (a_q_at[3] < 0 && a_out2[255:128] != 0) a_q_at[3] = i;
      if (b_q_at[0] < 0 && b_out1[127:0] != 0)   b_q_at[0] = i;
      if (b_q_at[1] < 0 && b_out2[127:0] != 0)   b_q_at[1] = i;
      if (b_q_at[2] < 0 && b_out1[255:128] != 0) b_q_at[2] = i;
      if (b_q_at[3] < 0 && b_out2[255:128] != 0) b_q_at[3] = i;
    end
  endtask

  task automatic test_reset();
    in_img = IMG_A;
    set_filters(18'h00011, 18'h00022, 18'h00033, 18'h00044);
    do_reset();
    n_checks++;
    if (a_dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", a_dbg_state); end
    n_checks++;
    if ({a_busy, a_done, a_l1_en, a_l2_en} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_flags: got %b expected 0000", {a_busy, a_done, a_l1_en, a_l2_en});
    end
    n_checks++;
    if (a_l1_img !== 288'h0) begin n_errors++; $display("FAIL reset_l1_img: got %h expected 0", a_l1_img); end
    n_checks++;
    if ({a_l1_filt, a_l2_filt} !== 36'h0) begin n_errors++; $display("FAIL reset_filts: got %h expected 0", {a_l1_filt, a_l2_filt}); end
    n_checks++;
    if (a_l2_map !== 200'h0) begin n_errors++; $display("FAIL reset_l2_map: got %h expected 0", a_l2_map); end
    n_checks++;
    if (a_out1 !== 256'h0 || a_out2 !== 256'h0) begin
      n_errors++; $display("FAIL reset_outs: got %h %h expected 0 0", a_out1, a_out2);
    end
    // Idle: start held low, inputs wiggling, nothing may change.
    for (int i = 0; i < 20; i++) begin
      in_img = {9{$urandom()}};
      f1 = 18'($urandom());
      tick();
      n_checks++;
      if ({a_busy, a_done, a_l1_en, a_l2_en} !== 4'b0000 || a_l1_img !== 288'h0 ||
          a_l1_filt !== 18'h0 || a_out1 !== 256'h0 || a_out2 !== 256'h0) begin
        n_errors++; $display("FAIL idle_hold cycle %0d: got busy=%b l1_filt=%h expected 0 0", i, a_busy, a_l1_filt);
      end
    end
  endtask

  task automatic test_mapping();
    do_reset();
    in_img = IMG_A;
    set_filters(18'h00001, 18'h00002, 18'h00003, 18'h00004);
    accept();
    run_monitor(30);
    n_checks++;
    if (a_done_at !== 12) begin n_errors++; $display("FAIL map_done_latency: got %0d expected 12", a_done_at); end
    n_checks++;
    if (a_done_cnt !== 1) begin n_errors++; $display("FAIL map_done_pulses: got %0d expected 1", a_done_cnt); end
    n_checks++;
    if (a_l1_cnt !== 4) begin n_errors++; $display("FAIL map_l1_en_cycles: got %0d expected 4", a_l1_cnt); end
    n_checks++;
    if (a_l2_cnt !== 8) begin n_errors++; $display("FAIL map_l2_en_cycles: got %0d expected 8", a_l2_cnt); end
    n_checks++;
    if (a_q_at[0] !== 4 || a_q_at[1] !== 6 || a_q_at[2] !== 10 || a_q_at[3] !== 12) begin
      n_errors++; $display("FAIL map_quadrant_times: got %0d %0d %0d %0d expected 4 6 10 12",
                           a_q_at[0], a_q_at[1], a_q_at[2], a_q_at[3]);
    end
    n_checks++;
    if (a_out1 !== {128'h3, 128'h1}) begin n_errors++; $display("FAIL map_out1: got %h expected %h", a_out1, {128'h3, 128'h1}); end
    n_checks++;
    if (a_out2 !== {128'h4, 128'h2}) begin n_errors++; $display("FAIL map_out2: got %h expected %h", a_out2, {128'h4, 128'h2}); end
    n_checks++;
    if (a_l2_map !== {182'b0, 18'h3}) begin n_errors++; $display("FAIL map_l2_map: got %h expected 3", a_l2_map); end
    n_checks++;
    if (a_l1_img !== IMG_A) begin n_errors++; $display("FAIL map_l1_img: got %h expected %h", a_l1_img, IMG_A); end
    n_checks++;
    if (a_busy !== 1'b0) begin n_errors++; $display("FAIL map_busy_end: got %b expected 0", a_busy); end
  endtask

  task automatic test_latency_sweep();
    do_reset();
    in_img = IMG_A;
    set_filters(18'h00001, 18'h00002, 18'h00003, 18'h00004);
    accept();
    run_monitor(30);
    n_checks++;
    if (b_done_at !== 22) begin n_errors++; $display("FAIL sweep_done_latency: got %0d expected 22", b_done_at); end
    n_checks++;
    if (b_done_cnt !== 1) begin n_errors++; $display("FAIL sweep_done_pulses: got %0d expected 1", b_done_cnt); end
    n_checks++;
    if (b_q_at[0] !== 6 || b_q_at[1] !== 11 || b_q_at[2] !== 17 || b_q_at[3] !== 22) begin
      n_errors++; $display("FAIL sweep_quadrant_times: got %0d %0d %0d %0d expected 6 11 17 22",
                           b_q_at[0], b_q_at[1], b_q_at[2], b_q_at[3]);
    end
    n_checks++;
    if (b_l1_cnt !== 2 || b_l2_cnt !== 20) begin
      n_errors++; $display("FAIL sweep_en_cycles: got %0d %0d expected 2 20", b_l1_cnt, b_l2_cnt);
    end
    n_checks++;
    if (b_out1 !== {128'h3, 128'h1} || b_out2 !== {128'h4, 128'h2}) begin
      n_errors++; $display("FAIL sweep_outs: got %h %h expected 3/1 4/2", b_out1, b_out2);
    end
  endtask

  task automatic test_busy_ignore();
    int done_at;
    int done_cnt;
    do_reset();
    in_img = IMG_A;
    set_filters(18'h00001, 18'h00002, 18'h00003, 18'h00004);
    accept();
    done_at = -1;
    done_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        start = 1'b1;
        in_img = ~IMG_A;
        set_filters(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF);
      end else begin
        start = 1'b0;
      end
      tick();
      if (a_done) begin done_cnt++; if (done_at < 0) done_at = i; end
    end
    n_checks++;
    if (done_at !== 12 || done_cnt !== 1) begin
      n_errors++; $display("FAIL busy_ignore_done: got at=%0d n=%0d expected at=12 n=1", done_at, done_cnt);
    end
    n_checks++;
    if (a_out1 !== {128'h3, 128'h1} || a_out2 !== {128'h4, 128'h2}) begin
      n_errors++; $display("FAIL busy_ignore_outs: got %h %h expected 3/1 4/2", a_out1, a_out2);
    end
    n_checks++;
    if (a_busy !== 1'b0 || a_l1_img !== IMG_A) begin
      n_errors++; $display("FAIL busy_ignore_not_queued: got busy=%b expected busy=0 with original image", a_busy);
    end
  endtask

  task automatic test_back_to_back();
    int done_at;
    do_reset();
    in_img = IMG_A;
    set_filters(18'h00001, 18'h00002, 18'h00003, 18'h00004);
    accept();
    done_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (a_done) begin done_at = i; break; end
    end
    n_checks++;
    if (done_at !== 12) begin n_errors++; $display("FAIL b2b_first_done: got %0d expected 12", done_at); end
    // Start presented during the done cycle.
    set_filters(18'h00005, 18'h00006, 18'h00007, 18'h00008);
    accept();
    n_checks++;
    if (a_busy !== 1'b1 || a_l1_filt !== 18'h5) begin
      n_errors++; $display("FAIL b2b_accept: got busy=%b l1_filt=%h expected busy=1 l1_filt=5", a_busy, a_l1_filt);
    end
    run_monitor(20);
    n_checks++;
    if (a_done_at !== 12 || a_done_cnt !== 1) begin
      n_errors++; $display("FAIL b2b_second_done: got at=%0d n=%0d expected at=12 n=1", a_done_at, a_done_cnt);
    end
    n_checks++;
    if (a_out1 !== {128'h7, 128'h5} || a_out2 !== {128'h8, 128'h6}) begin
      n_errors++; $display("FAIL b2b_outs: got %h %h expected 7/5 8/6", a_out1, a_out2);
    end
  endtask

  task automatic test_mid_reset();
    int done_cnt;
    do_reset();
    in_img = IMG_A;
    set_filters(18'h00001, 18'h00002, 18'h00003, 18'h00004);
    accept();
    for (int i = 1; i <= 6; i++) tick();
    n_checks++;
    if (a_out1[127:0] !== 128'h1 || a_busy !== 1'b1) begin
      n_errors++; $display("FAIL mid_reset_pre: got q0=%h busy=%b expected 1 1", a_out1[127:0], a_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({a_busy, a_done, a_l1_en, a_l2_en} !== 4'b0000 || a_out1 !== 256'h0 || a_out2 !== 256'h0 ||
        a_dbg_state !== 2'd0 || a_l2_map !== 200'h0) begin
      n_errors++; $display("FAIL mid_reset_clear: got busy=%b out1=%h expected 0 0", a_busy, a_out1);
    end
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_done || a_busy) done_cnt++;
    end
    n_checks++;
    if (done_cnt !== 0) begin n_errors++; $display("FAIL mid_reset_no_done: got %0d expected 0", done_cnt); end
    // rst and start on the same edge: rst wins.
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    n_checks++;
    if (a_busy !== 1'b0 || a_l1_filt !== 18'h0) begin
      n_errors++; $display("FAIL rst_over_start: got busy=%b l1_filt=%h expected 0 0", a_busy, a_l1_filt);
    end
  endtask

  task automatic test_isolation();
    logic [17:0] exp_q[$];
    logic [17:0] exp_l2;
    logic [17:0] exp_l1;
    do_reset();
    in_img = IMG_A;
    set_filters(18'h00001, 18'h00002, 18'h00003, 18'h00004);
    exp_q = '{18'h0, 18'h0, 18'h1, 18'h1, 18'h2, 18'h2, 18'h2, 18'h2,
              18'h3, 18'h3, 18'h4, 18'h4, 18'h4};
    accept();
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) begin
        in_img = {9{$urandom()}};
        set_filters(18'($urandom()), 18'($urandom()), 18'($urandom()), 18'($urandom()));
        tick();
      end
      exp_l2 = exp_q.pop_front();
      exp_l1 = (i < 6) ? 18'h1 : 18'h3;
      n_checks++;
      if (a_l1_img !== IMG_A || a_l1_filt !== exp_l1 || a_l2_filt !== exp_l2) begin
        n_errors++; $display("FAIL isolation cycle %0d: got l1_filt=%h l2_filt=%h expected %h %h",
                             i, a_l1_filt, a_l2_filt, exp_l1, exp_l2);
      end
    end
    n_checks++;
    if (a_done !== 1'b1 || a_out1 !== {128'h3, 128'h1} || a_out2 !== {128'h4, 128'h2}) begin
      n_errors++; $display("FAIL isolation_outs: got done=%b %h %h expected 1 3/1 4/2", a_done, a_out1, a_out2);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    start = 1'b0;
    in_img = '0;
    set_filters(18'h0, 18'h0, 18'h0, 18'h0);
    test_reset();
    test_mapping();
    test_latency_sweep();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_isolation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
